fifo_reader: RTL and testbench

Read-side engine for the team's synchronous `fifo`. Pops words through the FIFO's `r_ready`/`fifo_empty`/`data_out` port and re-presents them on a valid/ready output stream that downstream logic can stall. Output words are grouped into fixed-length packets by `m_last`. It sits between the FIFO and any consumer, such as a DMA engine or a SRAM writer, and is the counterpart to the producer that drives `w_valid`/`data_in`.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_skid.sv | 69 ++++++
 rtl/fifo_reader.sv | 131 +++++++++++++
 tb/tb_fifo_reader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the synchronous fifo and its read-side
// engine (fifo_reader).
//   DEFAULT_WIDTH : default data word width
//   RD_BUF_DEPTH  : depth of the reader's output buffer
//   RD_CNT_W      : width of the buffer occupancy count (0..RD_BUF_DEPTH)
//   beat_width()  : width of the packet beat counter, minimum 1 bit
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int RD_BUF_DEPTH  = 2;
    localparam int RD_CNT_W      = $clog2(RD_BUF_DEPTH + 1);

    function automatic int beat_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Small FIFO-ordered output buffer for fifo_reader. Words returned by the
// FIFO are pushed at the tail; the head is presented downstream and popped
// on accept. The caller guarantees no push when full (unless popping in the
// same cycle) and no pop when empty.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   push       in   write push_data at the tail
//   push_data  in   WIDTH  word to store
//   pop        in   advance the head
//   data       out  WIDTH  head entry
//   cnt        out  RD_CNT_W  number of stored words
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    data,
    output logic [RD_CNT_W-1:0] cnt
);

    // Pointers wrap by natural overflow, so RD_BUF_DEPTH must be a power of two.
    localparam int PTR_W = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;

    logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            // NOTE: the storage is reset too, because the head entry drives
            // m_data directly and m_data must read 0 after reset.
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign data = mem[head];

endmodule

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Read-side engine for the synchronous fifo. Pops words through the FIFO read
// port (r_ready / fifo_empty / data_out, one cycle read latency), buffers them
// in a 2-entry skid buffer and re-presents them on a valid/ready stream.
// Output beats are grouped into packets of PKT_LEN beats, marked by m_last.
//
// Parameters
//   WIDTH    data word width (must match the FIFO)
//   PKT_LEN  beats per packet, >= 1
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset (reset the FIFO with it)
//   enable      in   allow new pops; buffered/in-flight words always drain
//   fifo_empty  in   FIFO empty flag
//   r_ready     out  pop request to the FIFO
//   data_out    in   WIDTH  FIFO read data, valid the cycle after a pop
//   m_valid     out  output word valid
//   m_ready     in   downstream accept
//   m_data      out  WIDTH  output word (head of buffer)
//   m_last      out  last beat of a packet, qualified by m_valid
//   busy        out  a word is in flight or buffered
//
// Optional feature, enabled by defining FIFO_READER_STATS_EN:
//   stat_beats  out  32  accepted beats since reset (wraps)
//   stat_stalls out  32  cycles with m_valid && !m_ready since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             r_ready,
    input  logic [WIDTH-1:0] data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]      stat_beats,
    output logic [31:0]      stat_stalls
`endif
);

    localparam int                BEAT_W    = beat_width(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam int                OCC_W     = RD_CNT_W + 1;

    logic                inflight;
    logic [RD_CNT_W-1:0] cnt;
    logic                accept;
    logic [OCC_W-1:0]    occupancy;
    logic [BEAT_W-1:0]   beat;

    // Pop decision. Written as "occupancy < depth + accept" rather than
    // "occupancy - accept < depth" so the arithmetic never goes negative.
    // NOTE: every signal driven in always_comb gets a value on every path,
    // here by plain unconditional assignment, so no latch is inferred.
    always_comb begin
        accept    = m_valid && m_ready;
        occupancy = {1'b0, cnt} + OCC_W'(inflight);
        r_ready   = enable && !fifo_empty
                    && (occupancy < (OCC_W'(RD_BUF_DEPTH) + OCC_W'(accept)));
    end

    // A pop issued this cycle returns its word next cycle; reset drops any
    // pending return so a word arriving right after reset is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_ready;
        end
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (data_out),
        .pop       (accept),
        .data      (m_data),
        .cnt       (cnt)
    );

    assign m_valid = (cnt != '0);
    assign busy    = inflight || m_valid;
    assign m_last  = (beat == LAST_BEAT);

    // Beat position within the current packet; stays 0 when PKT_LEN is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
        end else if (accept) begin
            if (beat == LAST_BEAT) begin
                beat <= '0;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (m_valid && !m_ready) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
// Bench for fifo_reader. A behavioural FIFO (queue) feeds the DUT; every
// popped word is pushed into an expected-word queue, and a monitor compares
// each presented / accepted beat against it. Packet boundaries are predicted
// from the running count of accepted beats. Define FIFO_READER_STATS_EN to
// also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

    localparam int WIDTH   = 32;
    localparam int PKT_LEN = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             fifo_empty;
    logic             r_ready;
    logic [WIDTH-1:0] data_out;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
`ifdef FIFO_READER_STATS_EN
    logic [31:0]      stat_beats;
    logic [31:0]      stat_stalls;
`endif

    always #5 clk = ~clk;

    fifo_reader #(
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .r_ready    (r_ready),
        .data_out   (data_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
`ifdef FIFO_READER_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_stalls(stat_stalls)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural FIFO and scoreboard state ----------------
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               pop_pending = 1'b0;
    logic [WIDTH-1:0] pop_word;
    int               cyc = 0;
    int               n_pops = 0;
    int               n_acc = 0;
    int               n_stalls = 0;
    int               first_pop_cyc = -1;
    int               first_valid_cyc = -1;
    int               acc_cycs[$];
    logic             last_hist[$];

    always @(posedge clk) cyc++;

    // FIFO read side: a pop requested in a cycle is taken at the next edge.
    always @(negedge clk) begin
        if (!reset && r_ready && !fifo_empty) begin
            if (fifo_q.size() == 0) begin
                note_fail("pop_from_empty_model");
            end else begin
                pop_word    = fifo_q.pop_front();
                pop_pending = 1'b1;
                exp_q.push_back(pop_word);
                n_pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
        end
    end

    // Read data appears the cycle after the pop; otherwise it is junk.
    always @(posedge clk) begin
        #2;
        if (pop_pending) begin
            data_out    = pop_word;
            pop_pending = 1'b0;
        end else begin
            data_out = $urandom;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor: compare presented / accepted beats with the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (!enable) check("no_pop_when_disabled", r_ready, 1'b0);
            if (m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_word");
                end else begin
                    check("m_data", m_data, exp_q[0]);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        check("m_last", m_last, ((n_acc % PKT_LEN) == (PKT_LEN - 1)));
                        last_hist.push_back(m_last);
                        acc_cycs.push_back(cyc);
                        n_acc++;
                    end else begin
                        n_stalls++;
                    end
                end
            end
        end
    end

    // After each edge: words popped but not yet accepted are exactly the
    // DUT's in-flight plus buffered words, which can never exceed two.
    always @(posedge clk) begin
        #3;
        if (!reset) begin
            check("busy", busy, ((n_pops - n_acc) != 0));
            check("outstanding_le_2", ((n_pops - n_acc) <= 2), 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Resets DUT and the FIFO model together, starting immediately.
    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        pop_pending     = 1'b0;
        n_pops          = 0;
        n_acc           = 0;
        n_stalls        = 0;
        first_pop_cyc   = -1;
        first_valid_cyc = -1;
        acc_cycs.delete();
        last_hist.delete();
        step(2);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy && (fifo_q.size() == 0 || !enable)) return;
            step(1);
        end
        note_fail({name, "_timeout"});
    endtask

    initial begin
        int pops_at_drop;
        int wait_cnt;

        reset      = 1'b1;
        enable     = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        data_out   = '0;

        // ---- reset values ----
        step(2);
        @(negedge clk);
        check("rst_r_ready", r_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_m_last", m_last, (PKT_LEN == 1));
        check("rst_busy", busy, 1'b0);
`ifdef FIFO_READER_STATS_EN
        check("rst_stat_beats", stat_beats, '0);
        check("rst_stat_stalls", stat_stalls, '0);
`endif
        step(1);
        reset = 1'b0;

        // ---- streaming: 0..7, full throughput ----
        step(1);
        for (int i = 0; i < 8; i++) fifo_q.push_back(WIDTH'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        drain(60, "stream");
        check("stream_latency", first_valid_cyc - first_pop_cyc, 2);
        check("stream_count", n_acc, 8);
        if (acc_cycs.size() == 8) begin
            check("stream_back_to_back", acc_cycs[7] - acc_cycs[0], 7);
            check("stream_last_w0", last_hist[0], 1'b0);
            check("stream_last_w3", last_hist[3], 1'b1);
            check("stream_last_w7", last_hist[7], 1'b1);
        end

        // ---- backpressure: 0..5 with a 10 cycle stall ----
        step(1);
        do_reset();
        for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'(i));
        enable  = 1'b1;
        m_ready = 1'b0;
        step(10);
        @(negedge clk);
        check("bp_pops_during_stall", n_pops, 2);
        check("bp_r_ready_held_low", r_ready, 1'b0);
        check("bp_m_valid", m_valid, 1'b1);
        check("bp_m_data_head", m_data, '0);
        step(1);
        m_ready = 1'b1;
        drain(60, "bp");
        check("bp_delivered", n_acc, 6);
        check("bp_popped", n_pops, 6);

        // ---- enable drop while streaming ----
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(WIDTH'($urandom));
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        enable       = 1'b0;
        pops_at_drop = n_pops;
        check("drop_outstanding_le_2", ((n_pops - n_acc) <= 2), 1'b1);
        for (int i = 0; i < 4; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        m_ready  = 1'b1;
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 40) begin
            step(1);
            wait_cnt++;
        end
        check("drop_all_delivered", exp_q.size(), 0);
        check("drop_busy_falls", busy, 1'b0);
        check("drop_no_new_pops", n_pops, pops_at_drop);
        fifo_q.delete();

        // ---- randomized traffic ----
        step(1);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(WIDTH'($urandom));
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        drain(400, "random");
        check("random_no_loss", n_acc, n_pops);

        // ---- reset mid-packet ----
        do_reset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(WIDTH'(100 + i));
        enable   = 1'b1;
        m_ready  = 1'b1;
        wait_cnt = 0;
        while (n_acc < 2 && wait_cnt < 20) begin
            step(1);
            wait_cnt++;
        end
        check("mid_two_accepted", n_acc, 2);
        do_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'(200 + i));
        enable  = 1'b1;
        m_ready = 1'b1;
        drain(40, "mid");
        check("mid_count", n_acc, 4);
        if (last_hist.size() == 4) begin
            check("mid_last_beat2", last_hist[2], 1'b0);
            check("mid_last_beat4", last_hist[3], 1'b1);
        end

`ifdef FIFO_READER_STATS_EN
        // ---- statistics: 6 beats, 3 stall cycles ----
        step(1);
        do_reset();
        for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'(i));
        enable   = 1'b1;
        m_ready  = 1'b0;
        wait_cnt = 0;
        while (!m_valid && wait_cnt < 10) begin
            step(1);
            wait_cnt++;
        end
        step(3);
        m_ready = 1'b1;
        drain(40, "stats");
        @(negedge clk);
        check("stat_beats", stat_beats, 32'd6);
        check("stat_stalls", stat_stalls, 32'd3);
        check("stat_stalls_model", stat_stalls, n_stalls);
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
